// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction SRAM and
// applies ID redirects, parking them while stalled. Optional macro: IF_ADDR_ERR_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   output logic [32:0]        if_to_id_bus,
   output logic               inst_sram_en,
   output logic [3:0]         inst_sram_wen,
   output logic [31:0]        inst_sram_addr,
   output logic [31:0]        inst_sram_wdata
`ifdef IF_ADDR_ERR_EN
   ,
   output logic               if_adel
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD, HOLD_BR} state_t;

   state_t      state_r, state_nx;
   logic [31:0] pc_r, pc_nx;
   logic        ce_r, ce_nx;
   logic        pend_r, pend_nx;
   logic [31:0] pend_addr_r, pend_addr_nx;

   logic        br_e;
   logic [31:0] br_addr;
   logic        stall_pc;
   logic [31:0] next_pc;
   logic        unused_stall;

   assign br_e         = br_bus[32];
   assign br_addr      = br_bus[31:0];
   assign stall_pc     = stall[0];
   assign unused_stall = ^stall[STALL_W-1:1];

   // A parked redirect outranks anything ID presents in the release cycle.
   assign next_pc = pend_r ? pend_addr_r : (br_e ? br_addr : pc_r + 32'd4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= BOOT;
         pc_r        <= RESET_PC - 32'd4;
         ce_r        <= 1'b0;
         pend_r      <= 1'b0;
         pend_addr_r <= 32'd0;
      end else begin
         state_r     <= state_nx;
         pc_r        <= pc_nx;
         ce_r        <= ce_nx;
         pend_r      <= pend_nx;
         pend_addr_r <= pend_addr_nx;
      end
   end

   always_comb begin
      state_nx     = state_r;
      pc_nx        = pc_r;
      ce_nx        = ce_r;
      pend_nx      = pend_r;
      pend_addr_nx = pend_addr_r;
      case (state_r)
         BOOT: begin
            pc_nx    = RESET_PC;
            ce_nx    = 1'b1;
            state_nx = RUN;
         end
         RUN, HOLD: begin
            if (stall_pc) begin
               if (br_e) begin
                  pend_nx      = 1'b1;
                  pend_addr_nx = br_addr;
                  state_nx     = HOLD_BR;
               end else begin
                  state_nx = HOLD;
               end
            end else begin
               pc_nx    = next_pc;
               state_nx = RUN;
            end
         end
         HOLD_BR: begin
            if (stall_pc) begin
               if (br_e) pend_addr_nx = br_addr;
            end else begin
               pc_nx    = pend_addr_r;
               pend_nx  = 1'b0;
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   assign if_to_id_bus    = {ce_r, pc_r};
   assign inst_sram_addr  = pc_r;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_wdata = 32'd0;

`ifdef IF_ADDR_ERR_EN
   assign if_adel      = ce_r & (pc_r[1:0] != 2'b00);
   assign inst_sram_en = ce_r & ~if_adel;
`else
   assign inst_sram_en = ce_r;
`endif

endmodule
